// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: issues word requests to instruction memory,
// buffers up to two returned instructions and hands them to decode.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_addr,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam logic [2:0] CREDITS = 3'(DEPTH);

    logic [31:0] fetch_pc;
    logic [1:0]  outstanding;
    logic [1:0]  drop_cnt;
    logic [1:0]  fifo_count;
    logic        req_stale;

    logic [31:0] fifo_addr [2];
    logic [31:0] fifo_data [2];
    logic        rd_ptr;
    logic        wr_ptr;

    logic [31:0] tag_mem [2];
    logic        tag_rd;
    logic        tag_wr;

    logic        gnt_fire;
    logic        track_gnt;
    logic        issue;
    logic        push;
    logic        pop;
    logic [2:0]  credit_used;
    logic [31:0] pc_after;
    logic [31:0] target_pc;

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^redirect_pc[1:0];

    // NOTE: every signal written here gets a value first, so no latch can be inferred.
    always_comb begin
        gnt_fire    = imem_req && imem_gnt;
        // A request held across a redirect still completes, but must not advance the new stream.
        track_gnt   = gnt_fire && !req_stale && !redirect;
        pc_after    = track_gnt ? fetch_pc + 32'd4 : fetch_pc;
        target_pc   = {redirect_pc[31:2], 2'b00};
        credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
        issue       = !redirect && (!imem_req || imem_gnt) && (credit_used < CREDITS);
        push        = imem_rvalid && !redirect && (drop_cnt == 2'd0);
        pop         = inst_valid && inst_ready && !redirect;
    end

    assign inst_valid = (fifo_count != 2'd0);
    assign inst_data  = fifo_data[rd_ptr];
    assign inst_addr  = fifo_addr[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            fetch_pc    <= RESET_PC;
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
            req_stale   <= 1'b0;
        end else begin
            imem_req    <= (imem_req && !imem_gnt) || issue;
            if (issue) begin
                imem_addr <= pc_after;
            end
            fetch_pc    <= redirect ? target_pc : pc_after;
            outstanding <= outstanding + 2'(issue) - 2'(imem_rvalid);

            if (redirect) begin
                drop_cnt <= outstanding - 2'(imem_rvalid);
            end else if (imem_rvalid && (drop_cnt != 2'd0)) begin
                drop_cnt <= drop_cnt - 2'd1;
            end

            if (redirect) begin
                req_stale <= imem_req && !imem_gnt;
            end else if (gnt_fire) begin
                req_stale <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            tag_rd     <= 1'b0;
            tag_wr     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= !wr_ptr;
                tag_rd <= !tag_rd;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            if (track_gnt) begin
                tag_wr <= !tag_wr;
            end
            fifo_count <= fifo_count + 2'(push) - 2'(pop);
        end
    end

    // NOTE: the storage is reset because decode observes the head as inst_data/inst_addr straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_addr[i] <= 32'd0;
                fifo_data[i] <= 32'd0;
                tag_mem[i]   <= 32'd0;
            end
        end else begin
            if (push) begin
                fifo_addr[wr_ptr] <= tag_mem[tag_rd];
                fifo_data[wr_ptr] <= imem_rdata;
            end
            if (track_gnt) begin
                tag_mem[tag_wr] <= imem_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            assert (fifo_count != 2'd2);
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomised bench for fetch_ctrl: a memory model plus an epoch-based
// reference of the instruction stream that decode must observe.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_addr;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_addr(inst_addr),
        .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = !clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    pend_t       pend[$];
    ent_t        fifo_q[$];
    logic [31:0] req_log[$];
    logic [31:0] deliv_log[$];
    int unsigned cur_epoch;
    int unsigned req_epoch;
    logic [31:0] next_req;
    logic [31:0] deliver_ptr;
    int          cyc;
    int          gnt_pct, rv_pct, rdy_pct, lat_max;
    int          n_tests;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        imem_gnt = imem_req && ($urandom_range(0, 99) < gnt_pct);
        if (pend.size() != 0 && pend[0].due <= cyc && $urandom_range(0, 99) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].addr ^ KEY;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        inst_ready  = ($urandom_range(0, 99) < rdy_pct);
        redirect    = 1'b0;
        redirect_pc = $urandom;
    endtask

    // Apply the upcoming edge to the reference, then compare the DUT after it.
    task automatic tick();
        pend_t       p;
        ent_t        e;
        bit          hs, keep, rdr, was_held, ok;
        logic [31:0] held_addr;
        hs   = (fifo_q.size() != 0) && inst_ready;
        keep = 1'b0;
        e    = '{32'd0, 32'd0};
        if (hs) begin
            check("deliver_addr", inst_addr, deliver_ptr);
            check("deliver_data", inst_data, deliver_ptr ^ KEY);
            deliv_log.push_back(inst_addr);
            deliver_ptr += 32'd4;
        end
        if (imem_rvalid) begin
            p    = pend.pop_front();
            keep = (p.epoch == cur_epoch) && !redirect;
            e    = '{p.addr, imem_rdata};
        end
        if (imem_req && imem_gnt) begin
            p.addr  = imem_addr;
            p.epoch = req_epoch;
            p.due   = cyc + 1 + int'($urandom_range(0, lat_max));
            pend.push_back(p);
        end
        if (hs) void'(fifo_q.pop_front());
        if (keep) fifo_q.push_back(e);
        rdr = redirect;
        if (redirect) begin
            cur_epoch++;
            fifo_q.delete();
            next_req    = {redirect_pc[31:2], 2'b00};
            deliver_ptr = next_req;
        end
        was_held  = imem_req && !imem_gnt;
        held_addr = imem_addr;

        @(posedge clk);
        #1;
        cyc++;

        if (was_held) begin
            check("hold_req", imem_req, 1'b1);
            check("hold_addr", imem_addr, held_addr);
        end else begin
            if (rdr) check("no_issue_on_redirect", imem_req, 1'b0);
            if (imem_req) begin
                check("req_addr", imem_addr, next_req);
                req_log.push_back(imem_addr);
                next_req += 32'd4;
                req_epoch = cur_epoch;
            end
        end
        ok = (pend.size() + int'(imem_req) + fifo_q.size()) <= 2;
        check("credit_invariant", ok, 1'b1);
        check("inst_valid", inst_valid, fifo_q.size() != 0);
        if (fifo_q.size() != 0) begin
            check("inst_addr", inst_addr, fifo_q[0].addr);
            check("inst_data", inst_data, fifo_q[0].data);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_inst_addr", inst_addr, 32'd0);
        rst = 1'b0;
        pend.delete();
        fifo_q.delete();
        cur_epoch++;
        req_epoch   = cur_epoch;
        next_req    = RESET_PC;
        deliver_ptr = RESET_PC;
    endtask

    task automatic knobs(input int g, input int rv, input int rdy, input int lat);
        gnt_pct = g;
        rv_pct  = rv;
        rdy_pct = rdy;
        lat_max = lat;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx, didx, start;
        bit  hit;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        cur_epoch = 0;

        // 1: straight-line fetch from RESET_PC
        knobs(100, 100, 100, 0);
        do_reset();
        for (int i = 0; i < 20; i++) begin drive(); tick(); end
        check("t1_deliv_count", deliv_log.size() >= 3, 1'b1);
        if (deliv_log.size() >= 3) begin
            check("t1_first", deliv_log[0], 32'h100);
            check("t1_second", deliv_log[1], 32'h104);
            check("t1_third", deliv_log[2], 32'h108);
        end

        // 2: decode stalled -> exactly two requests then silence
        knobs(100, 100, 0, 0);
        do_reset();
        req_log.delete();
        deliv_log.delete();
        for (int i = 0; i < 10; i++) begin drive(); tick(); end
        check("t2_req_count", req_log.size(), 32'd2);
        check("t2_req_idle", imem_req, 1'b0);
        check("t2_head_addr", inst_addr, 32'h100);
        rdy_pct = 100;
        for (int i = 0; i < 12; i++) begin drive(); tick(); end
        check("t2_resume", deliv_log.size() >= 3, 1'b1);
        if (deliv_log.size() >= 3) check("t2_third", deliv_log[2], 32'h108);

        // 3: grant withheld for 5 cycles on the 0x104 request
        knobs(100, 100, 100, 0);
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            drive();
            tick();
            hit = imem_req && (imem_addr == 32'h104);
        end
        check("t3_reach_104", hit, 1'b1);
        gnt_pct = 0;
        for (int i = 0; i < 5; i++) begin
            drive();
            tick();
            check("t3_held_req", imem_req, 1'b1);
            check("t3_held_addr", imem_addr, 32'h104);
        end
        gnt_pct = 100;
        idx = req_log.size();
        for (int i = 0; i < 8; i++) begin drive(); tick(); end
        check("t3_next_seen", req_log.size() > idx, 1'b1);
        if (req_log.size() > idx) check("t3_next_addr", req_log[idx], 32'h108);

        // 4: redirect with two requests outstanding
        knobs(100, 0, 100, 0);
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            drive();
            tick();
            hit = (pend.size() == 2);
        end
        check("t4_two_outstanding", hit, 1'b1);
        idx  = req_log.size();
        didx = deliv_log.size();
        drive();
        redirect    = 1'b1;
        redirect_pc = 32'h2003;
        tick();
        rv_pct = 100;
        for (int i = 0; i < 20; i++) begin drive(); tick(); end
        check("t4_req_seen", req_log.size() > idx, 1'b1);
        if (req_log.size() > idx) check("t4_first_req", req_log[idx], 32'h2000);
        check("t4_deliv_seen", deliv_log.size() > didx, 1'b1);
        if (deliv_log.size() > didx) check("t4_first_deliv", deliv_log[didx], 32'h2000);

        // 5: redirect coinciding with rvalid and a decode handshake
        knobs(100, 100, 0, 0);
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            drive();
            if (fifo_q.size() != 0 && imem_rvalid) begin
                inst_ready  = 1'b1;
                redirect    = 1'b1;
                redirect_pc = 32'h3000;
                hit         = 1'b1;
                didx        = deliv_log.size() + 1;
            end
            tick();
        end
        check("t5_scenario", hit, 1'b1);
        check("t5_flushed", inst_valid, 1'b0);
        rdy_pct = 100;
        for (int i = 0; i < 20; i++) begin drive(); tick(); end
        if (hit) begin
            check("t5_handshake", deliv_log.size() > didx, 1'b1);
            if (deliv_log.size() > didx) check("t5_first_after", deliv_log[didx], 32'h3000);
        end

        // 6: address wrap
        knobs(100, 100, 100, 0);
        idx = req_log.size();
        drive();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        for (int i = 0; i < 10; i++) begin drive(); tick(); end
        check("t6_reqs", req_log.size() > idx + 1, 1'b1);
        if (req_log.size() > idx + 1) begin
            check("t6_top", req_log[idx], 32'hFFFF_FFFC);
            check("t6_wrap", req_log[idx + 1], 32'h0000_0000);
        end

        // Random traffic with occasional redirects
        start = deliv_log.size();
        for (int seg = 0; seg < 12; seg++) begin
            knobs(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                  int'($urandom_range(20, 100)), int'($urandom_range(0, 3)));
            for (int i = 0; i < 300; i++) begin
                drive();
                if ($urandom_range(0, 99) < 4) redirect = 1'b1;
                tick();
            end
        end
        check("random_progress", deliv_log.size() > start, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer placed in front of the core's decoder. It owns the fetch PC, issues word requests to instruction memory over a req/gnt/rvalid protocol, and buffers up to 2 returned instructions in a FIFO. It presents them to decode with a valid/ready handshake. It also handles control-flow redirects by flushing the FIFO and discarding in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)
DEPTH, 2, maximum of FIFO entries plus in-flight requests (fixed at 2; other values unsupported)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  request valid toward instruction memory
imem_addr  output  32  word address of request, bits [1:0] always 0
imem_gnt  input  1  request accepted this cycle (meaningful only while imem_req=1)
imem_rvalid  input  1  response data valid; in order; at least 1 cycle after its gnt
imem_rdata  input  32  response instruction word
inst_valid  output  1  FIFO head valid toward decode
inst_data  output  32  FIFO head instruction
inst_addr  output  32  PC of FIFO head instruction
inst_ready  input  1  decode consumes head when inst_valid && inst_ready
redirect  input  1  control-flow change; flush and restart
redirect_pc  input  32  new fetch PC; bits [1:0] ignored (treated as 0)

Behaviour:
- Reset (rst=1 at edge): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0; outputs imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_addr=0. A reset mid-transaction abandons all state, with no drain. Memory-side cleanup is the memory's responsibility.
- Tracked state:
  - fetch_pc: address of the next request.
  - outstanding (0..2): requests asserted or granted whose response has not yet arrived, including a held un-granted request.
  - fifo_count (0..2).
  - drop_cnt (0..2).
- Issue rule: when imem_req=0, assert imem_req with imem_addr=fetch_pc next cycle if (registered) outstanding + fifo_count < 2 and redirect=0. Use registered counts only, with no same-cycle bypass of dequeue/rvalid.
- Hold rule: once asserted, imem_req and imem_addr stay stable until the imem_gnt cycle, even across a redirect.
- On the gnt cycle:
  - fetch_pc += 4, wrapping modulo 2^32.
  - imem_req drops next cycle unless the issue rule holds again. Back-to-back requests are allowed.
- Response (imem_rvalid=1):
  - outstanding decrements.
  - If drop_cnt>0: decrement drop_cnt and discard the data.
  - Otherwise push {pc, data} into the FIFO. The pc tag comes from an internal in-order tag queue recorded at gnt.
  - The credit rule guarantees the FIFO is never full on push. A push when full is an assertion failure.
- Dequeue: on inst_valid && inst_ready, pop the head. inst_valid/inst_data/inst_addr come from the FIFO head (registered storage), so the first instruction appears 1 cycle after its rvalid. Simultaneous push and pop is allowed.
- Redirect (redirect=1), applied at that edge:
  - FIFO cleared; inst_valid=0 next cycle.
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - drop_cnt = outstanding − (imem_rvalid ? 1 : 0). The response arriving in the redirect cycle is also discarded.
  - A held un-granted request is counted in drop_cnt and must still complete.
  - No new request is issued in the redirect cycle.
  - A handshake in the same cycle as redirect counts as consumed.
  - Redirect while drop_cnt>0 recomputes drop_cnt by the same rule.
- Steady-state throughput with 1-cycle memory latency and inst_ready=1: 1 instruction per 2 cycles is acceptable. Correctness outranks throughput.
- Invariant: outstanding + fifo_count ≤ 2 at all times.

Test Plan:
1. Reset with RESET_PC=32'h100, imem_gnt=1, rvalid 1 cycle after gnt, rdata=addr^32'hA5A5_0000, inst_ready=1 → requests to 0x100, 0x104, 0x108 in order. Decode sees inst_addr 0x100/0x104/0x108 with matching data. No duplicates, no gaps.
2. inst_ready=0 held for 10 cycles → exactly 2 requests issued, then imem_req stays 0 and FIFO holds 0x100, 0x104. Releasing inst_ready delivers them, then fetch resumes at 0x108.
3. imem_gnt=0 for 5 cycles during a request at 0x104 → imem_req=1 and imem_addr=0x104 stable all 5 cycles; fetch_pc advances only after gnt.
4. Redirect to 32'h2003 with 2 requests outstanding → both responses discarded, FIFO empty. The next request address is 0x2000, and the first delivered inst_addr is 0x2000.
5. Redirect in the same cycle as imem_rvalid and an inst handshake → the rvalid data is dropped, the handshake counts, drop_cnt = outstanding−1, and no stale instruction is delivered afterwards.
6. Wrap: redirect to 32'hFFFF_FFFC → requests to 0xFFFF_FFFC then 0x0000_0000.
